// File: rtl/xlib_feeder_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// xlib_feeder_pkg : shared FSM states, ordered-pair layout and gap limit
// rev 1.0
// -----------------------------------------------------------------------------
package xlib_feeder_pkg;

  localparam int GAP_MAX    = 15;
  localparam int GAP_CNT_W  = $clog2(GAP_MAX + 1);
  localparam int PAIR_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } feed_state_t;

  // Field order matches the flattened FIFO word {a, b, swapped}; operands are
  // carried zero-extended to PAIR_W_MAX bits.
  typedef struct packed {
    logic [PAIR_W_MAX-1:0] a;
    logic [PAIR_W_MAX-1:0] b;
    logic                  swapped;
  } pair_t;

endpackage
`default_nettype wire

// File: rtl/xlib_pair_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// xlib_pair_fifo : DEPTH-entry FIFO of ordered pairs {a, b, swapped}
// rev 1.0
// -----------------------------------------------------------------------------
module xlib_pair_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [2*WIDTH:0]       push_data,
  input  logic                   pop,
  output logic [2*WIDTH:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2 * WIDTH + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

  // Same index with differing wrap bits means the writer lapped the reader.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/xlib_operand_feeder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// xlib_operand_feeder : orders operand pairs (A>=B), queues and paces them
// rev 1.0
// -----------------------------------------------------------------------------
module xlib_operand_feeder
  import xlib_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_x,
  input  logic [WIDTH-1:0]       in_y,
  output logic [WIDTH-1:0]       a,
  output logic [WIDTH-1:0]       b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   swapped,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            issued
);

  localparam int                   DW       = 2 * WIDTH + 1;
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP);

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_y_gt_x;
  logic [DW-1:0]        w_push_data;
  logic [DW-1:0]        w_head;

  feed_state_t          r_state;
  feed_state_t          w_state_nxt;
  logic [GAP_CNT_W-1:0] r_gap_cnt;
  logic [GAP_CNT_W-1:0] w_gap_cnt_nxt;
  logic                 r_out_valid;
  logic                 w_out_valid_nxt;
  logic                 w_load_out;
  logic                 w_consume;

  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_swapped;
  logic [15:0]          r_issued;

  // Ordering happens on entry so the FIFO only ever holds A>=B pairs.
  assign w_y_gt_x    = (in_y > in_x);
  assign w_push_data = w_y_gt_x ? {in_y, in_x, 1'b1} : {in_x, in_y, 1'b0};
  assign in_ready    = !rst && !w_full;
  assign w_push      = in_valid && in_ready;
  assign w_consume   = (r_state == ST_ISSUE) && out_ready;

  xlib_pair_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_load_out),
    .head      (w_head),
    .count     (count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_out_valid_nxt = r_out_valid;
    w_load_out      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_load_out      = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
          if (GAP == 0) begin
            if (!w_empty) begin
              w_load_out = 1'b1;
            end else begin
              w_out_valid_nxt = 1'b0;
              w_state_nxt     = ST_IDLE;
            end
          end else begin
            w_out_valid_nxt = 1'b0;
            w_gap_cnt_nxt   = GAP_LOAD;
            w_state_nxt     = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt <= GAP_CNT_W'(1)) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gap_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_swapped   <= 1'b0;
      r_issued    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_consume) r_issued <= r_issued + 16'd1;
      if (w_load_out) {r_a, r_b, r_swapped} <= w_head;
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign swapped   = r_swapped;
  assign out_valid = r_out_valid;
  assign issued    = r_issued;

endmodule
`default_nettype wire
